spike_rate_decoder: RTL and testbench

//   Receive-side counterpart of spiking_neuron: converts a 1-bit spike train back into an
//   8-bit rate value. Counts rising edges of spike_in over a programmable window of clock

---
 rtl/spike_rate_decoder.sv | 172 +++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts rising edges of spike_in over back-to-back windows of win_len
// cycles and delivers each count on a valid/ready port. Optional ISI output: SPIKE_DECODER_ISI_EN.
module spike_rate_decoder #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spike_in,
  input  logic                enable,
  input  logic [WINDOW_W-1:0] win_len,
  output logic [COUNT_W-1:0]  rate_out,
  output logic                rate_valid,
  input  logic                rate_ready,
  output logic                overflow,
  output logic                overrun,
`ifdef SPIKE_DECODER_ISI_EN
  output logic [WINDOW_W-1:0] isi_out,
`endif
  output logic                busy
);

  // state   | meaning
  // S_IDLE  | not counting; a held result may still drain
  // S_COUNT | sampling spike_in, windows running back-to-back
  typedef enum logic {S_IDLE = 1'b0, S_COUNT = 1'b1} state_e;

  localparam logic [COUNT_W-1:0]  CNT_MAX = '1;
  localparam logic [COUNT_W-1:0]  CNT_ONE = COUNT_W'(1);
  localparam logic [WINDOW_W-1:0] WIN_ONE = WINDOW_W'(1);

  state_e              state_q, state_d;
  logic [WINDOW_W-1:0] remain_q, remain_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                wovf_q, wovf_d, wovf_inc;
  logic                spike_prev_q;
  logic [COUNT_W-1:0]  rate_q, rate_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                overrun_q, overrun_d;
  logic                edge_det, start, sample, win_end, xfer, cnt_max;

  assign edge_det = spike_in & ~spike_prev_q;
  assign start    = (state_q == S_IDLE) & enable;
  assign sample   = (state_q == S_COUNT) & enable;
  // remain_q is a down-counter loaded with N-1, so win_len=0 wraps to a 2**WINDOW_W window
  assign win_end  = sample & (remain_q == '0);
  assign xfer     = valid_q & rate_ready;
  assign cnt_max  = (cnt_q == CNT_MAX);
  assign cnt_inc  = (edge_det & ~cnt_max) ? cnt_q + CNT_ONE : cnt_q;
  assign wovf_inc = wovf_q | (edge_det & cnt_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable)  state_d = S_COUNT;
      S_COUNT: if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_COUNT);
    rate_out   = rate_q;
    rate_valid = valid_q;
    overflow   = ovf_q;
    overrun    = overrun_q;
  end

  always_comb begin
    remain_d  = remain_q;
    cnt_d     = cnt_q;
    wovf_d    = wovf_q;
    rate_d    = rate_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (start || win_end) begin
      remain_d = win_len - WIN_ONE;
      cnt_d    = '0;
      wovf_d   = 1'b0;
    end else if (sample) begin
      remain_d = remain_q - WIN_ONE;
      cnt_d    = cnt_inc;
      wovf_d   = wovf_inc;
    end
    if (win_end) begin
      rate_d  = cnt_inc;
      ovf_d   = wovf_inc;
      valid_d = 1'b1;
      if (valid_q & ~rate_ready) overrun_d = 1'b1;
      else if (xfer)             overrun_d = 1'b0;
    end else if (xfer) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_prev_q <= 1'b0;
      remain_q     <= '0;
      cnt_q        <= '0;
      wovf_q       <= 1'b0;
      rate_q       <= '0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      spike_prev_q <= spike_in;
      remain_q     <= remain_d;
      cnt_q        <= cnt_d;
      wovf_q       <= wovf_d;
      rate_q       <= rate_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SPIKE_DECODER_ISI_EN
  localparam logic [WINDOW_W-1:0] GAP_MAX = '1;

  logic [WINDOW_W-1:0] gap_q, gap_d, gap_step;
  logic [WINDOW_W-1:0] isi_win_q, isi_win_d, isi_cur;
  logic [WINDOW_W-1:0] isi_q, isi_d;
  logic                seen_q, seen_d;

  // gap_q counts cycles since the last edge; the interval to a new edge is gap_q+1
  assign gap_step = (gap_q == GAP_MAX) ? GAP_MAX : gap_q + WIN_ONE;
  assign isi_cur  = (sample & edge_det & seen_q) ? gap_step : isi_win_q;

  always_comb begin
    gap_d     = gap_q;
    isi_win_d = isi_win_q;
    seen_d    = seen_q;
    isi_d     = isi_q;
    if (start || win_end) begin
      gap_d     = '0;
      isi_win_d = '0;
      seen_d    = 1'b0;
    end else if (sample) begin
      gap_d     = edge_det ? '0 : gap_step;
      isi_win_d = isi_cur;
      seen_d    = seen_q | edge_det;
    end
    if (win_end) isi_d = isi_cur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q     <= '0;
      isi_win_q <= '0;
      seen_q    <= 1'b0;
      isi_q     <= '0;
    end else begin
      gap_q     <= gap_d;
      isi_win_q <= isi_win_d;
      seen_q    <= seen_d;
      isi_q     <= isi_d;
    end
  end

  assign isi_out = isi_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: window-level reference model checked every cycle on two
// instances (COUNT_W=8 and COUNT_W=4), plus directed cases with literal expectations.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spike_in = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] win_len = 8'd0;
  logic       rate_ready = 1'b0;

  logic [7:0] rate_out8;
  logic       rate_valid8, overflow8, overrun8, busy8;
  logic [3:0] rate_out4;
  logic       rate_valid4, overflow4, overrun4, busy4;

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .spike_in(spike_in), .enable(enable), .win_len(win_len),
    .rate_out(rate_out8), .rate_valid(rate_valid8), .rate_ready(rate_ready),
    .overflow(overflow8), .overrun(overrun8), .busy(busy8)
  );

  spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .spike_in(spike_in), .enable(enable), .win_len(win_len),
    .rate_out(rate_out4), .rate_valid(rate_valid4), .rate_ready(rate_ready),
    .overflow(overflow4), .overrun(overrun4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect the window's spike samples, count rising edges at window end.
  bit m_run = 1'b0;
  int m_n = 0;
  bit m_pre = 1'b0;
  bit m_win[$];
  bit m_valid = 1'b0;
  int m_rate8 = 0, m_rate4 = 0;
  bit m_ovf8 = 1'b0, m_ovf4 = 1'b0, m_overrun = 1'b0;
  bit m_xf, m_end;
  int m_e;

  function automatic int count_edges();
    int n = 0;
    bit prev = m_pre;
    foreach (m_win[i]) begin
      if (m_win[i] && !prev) n++;
      prev = m_win[i];
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_n = 0; m_pre = 1'b0; m_win.delete();
      m_valid = 1'b0; m_rate8 = 0; m_rate4 = 0;
      m_ovf8 = 1'b0; m_ovf4 = 1'b0; m_overrun = 1'b0;
    end else begin
      m_xf  = m_valid && rate_ready;
      m_end = 1'b0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1'b1;
          m_n = (win_len == 0) ? 256 : int'(win_len);
          m_pre = spike_in;
          m_win.delete();
        end
      end else if (!enable) begin
        m_run = 1'b0;
      end else begin
        m_win.push_back(spike_in);
        if (m_win.size() == m_n) begin
          m_e = count_edges();
          m_rate8 = (m_e > 255) ? 255 : m_e;
          m_ovf8  = (m_e > 255);
          m_rate4 = (m_e > 15) ? 15 : m_e;
          m_ovf4  = (m_e > 15);
          if (m_valid && !rate_ready) m_overrun = 1'b1;
          else if (m_xf)              m_overrun = 1'b0;
          m_valid = 1'b1;
          m_end = 1'b1;
          m_n = (win_len == 0) ? 256 : int'(win_len);
          m_pre = spike_in;
          m_win.delete();
        end
      end
      if (!m_end && m_xf) begin
        m_valid = 1'b0;
        m_overrun = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid8", rate_valid8, m_valid);
      chk("rate8", rate_out8, m_rate8);
      chk("ovf8", overflow8, m_ovf8);
      chk("overrun8", overrun8, m_overrun);
      chk("busy8", busy8, m_run);
      chk("valid4", rate_valid4, m_valid);
      chk("rate4", rate_out4, m_rate4);
      chk("ovf4", overflow4, m_ovf4);
      chk("overrun4", overrun4, m_overrun);
    end
  end

  int exp1[4] = '{3, 3, 4, 3};
  bit p4[10] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
  bit p5[8]  = '{1, 0, 0, 0, 1, 0, 1, 0};
  bit p6[5]  = '{1, 0, 1, 0, 0};

  task automatic go_idle(input int n);
    enable = 1'b0;
    spike_in = 1'b0;
    rate_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rate", rate_out8, 0);
    chk("rst_valid", rate_valid8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_overrun", overrun8, 0);
    chk("rst_ovf", overflow8, 0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // pulses every 3rd cycle, 10-cycle windows
    rate_ready = 1'b1;
    win_len = 8'd10;
    enable = 1'b1;
    for (int i = 0; i < 45; i++) begin
      spike_in = (i % 3 == 0);
      @(negedge clk);
      if (i >= 10 && i % 10 == 0 && i <= 40) begin
        chk("t1_valid", rate_valid8, 1);
        chk("t1_rate", rate_out8, exp1[i/10 - 1]);
      end else if (i >= 1) begin
        chk("t1_valid_low", rate_valid8, 0);
      end
    end
    go_idle(3);

    // spike held across a whole window counts once
    win_len = 8'd4;
    enable = 1'b1;
    @(negedge clk);
    spike_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("t2_valid", rate_valid8, 1);
    chk("t2_rate", rate_out8, 1);
    chk("t2_busy", busy8, 1);
    spike_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_valid2", rate_valid8, 1);
    chk("t2_rate2", rate_out8, 0);
    go_idle(3);

    // 256-cycle window, toggling spike
    win_len = 8'd0;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      spike_in = (i % 2 == 0);
      @(negedge clk);
    end
    chk("t3_valid", rate_valid8, 1);
    chk("t3_rate8", rate_out8, 128);
    chk("t3_ovf8", overflow8, 0);
    chk("t3_rate4", rate_out4, 15);
    chk("t3_ovf4", overflow4, 1);
    go_idle(3);

    // two window ends without ready -> overrun
    rate_ready = 1'b0;
    win_len = 8'd5;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      spike_in = p4[i];
      @(negedge clk);
      if (i == 4) begin
        chk("t4_valid1", rate_valid8, 1);
        chk("t4_rate1", rate_out8, 1);
        chk("t4_overrun1", overrun8, 0);
      end
    end
    chk("t4_valid2", rate_valid8, 1);
    chk("t4_rate2", rate_out8, 2);
    chk("t4_overrun2", overrun8, 1);
    enable = 1'b0;
    spike_in = 1'b0;
    rate_ready = 1'b1;
    @(negedge clk);
    chk("t4_drained", rate_valid8, 0);
    chk("t4_overrun_clr", overrun8, 0);
    chk("t4_busy", busy8, 0);
    go_idle(2);

    // ready on the exact window-end cycle
    rate_ready = 1'b0;
    win_len = 8'd4;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      spike_in = p5[i];
      rate_ready = (i == 7);
      @(negedge clk);
      if (i == 3) chk("t5_rate1", rate_out8, 1);
    end
    chk("t5_valid", rate_valid8, 1);
    chk("t5_rate2", rate_out8, 2);
    chk("t5_overrun", overrun8, 0);
    go_idle(3);

    // abort mid-window after two spikes
    win_len = 8'd20;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      spike_in = p6[i];
      @(negedge clk);
    end
    enable = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy8, 0);
    chk("t6_valid", rate_valid8, 0);
    repeat (3) @(negedge clk);
    chk("t6_valid_later", rate_valid8, 0);

    // async reset mid-window with a result held
    rate_ready = 1'b0;
    win_len = 8'd3;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      spike_in = (i == 0);
      @(negedge clk);
    end
    chk("t6_held_valid", rate_valid8, 1);
    chk("t6_held_rate", rate_out8, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_ar_rate", rate_out8, 0);
    chk("t6_ar_valid", rate_valid8, 0);
    chk("t6_ar_busy", busy8, 0);
    chk("t6_ar_overrun", overrun8, 0);
    chk("t6_ar_ovf", overflow8, 0);
    chk("t6_ar_valid4", rate_valid4, 0);
    @(negedge clk);
    reset = 1'b0;
    go_idle(2);

    // randomized traffic
    enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      spike_in = 1'($urandom_range(0, 1));
      rate_ready = ($urandom_range(0, 3) != 0);
      win_len = ($urandom_range(0, 20) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      if ($urandom_range(0, 80) == 0) enable = ~enable;
      if ($urandom_range(0, 500) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    go_idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
